// File: rtl/quad_cmd_pkg.sv
// rtl/quad_cmd_pkg.sv - shared opcodes, frame constants and FSM state types for the remote command path
package quad_cmd_pkg;

    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam int         FRAME_BYTES = 3;
    localparam logic [7:0] ACK         = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        WAIT_HI  = 2'd1,
        WAIT_LO  = 2'd2
    } asm_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 LSB-first byte receiver with RX synchroniser and glitch-rejecting start detect
module uart_rx_byte
    import quad_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_vld_o,
    output logic       frm_err_o,
    output logic       rx_busy_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    logic            rx_meta_q, rx_sync_q, rx_last_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            fall;

    assign fall       = rx_last_q & ~rx_sync_q;
    assign rx_byte_o  = sh_q;
    assign rx_busy_o  = (state_q != RX_IDLE);

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_last_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_last_q <= rx_sync_q;
        end
    end

    // Receiver state, baud counter, bit counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    // Next-state: sample when the baud counter hits zero, reload on every sample
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        byte_vld_o = 1'b0;
        frm_err_o  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = FULL_M1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {rx_sync_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    cnt_d = FULL_M1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d    = RX_IDLE;
                    byte_vld_o = rx_sync_q;
                    frm_err_o  = ~rx_sync_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/remote_cmd_rx.sv
// rtl/remote_cmd_rx.sv - assembles 3-byte remote frames into cmd/data with cmd_rdy handshake and gap timeout
module remote_cmd_rx
    import quad_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_TO   = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        frm_err,
    output logic        gap_err
);

    localparam int GW = $clog2(GAP_TO + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TO);

    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        rx_frm_err;
    logic        rx_busy;

    asm_state_t  asm_q, asm_d;
    logic [7:0]  cmd_sh_q, cmd_sh_d;
    logic [7:0]  hi_sh_q, hi_sh_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        rdy_q, rdy_d;
    logic [GW-1:0] gap_q, gap_d;
    logic        in_frame;
    logic        gap_run;
    logic        gap_hit;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (RX),
        .rx_byte_o  (rx_byte),
        .byte_vld_o (byte_vld),
        .frm_err_o  (rx_frm_err),
        .rx_busy_o  (rx_busy)
    );

    assign in_frame = (asm_q == WAIT_HI) || (asm_q == WAIT_LO);
    assign gap_run  = in_frame && !rx_busy;
    assign gap_hit  = in_frame && (gap_q == GAP_MAX);

    assign cmd_rdy  = rdy_q;
    assign cmd      = cmd_q;
    assign data     = data_q;
    assign frm_err  = rx_frm_err;
    assign gap_err  = gap_hit;

    // Assembly state, shadow bytes, output registers and gap timer
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q    <= WAIT_CMD;
            cmd_sh_q <= '0;
            hi_sh_q  <= '0;
            cmd_q    <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            gap_q    <= '0;
        end else begin
            asm_q    <= asm_d;
            cmd_sh_q <= cmd_sh_d;
            hi_sh_q  <= hi_sh_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            gap_q    <= gap_d;
        end
    end

    // Frame assembly; a timeout or framing error abandons the frame but keeps the last command
    always_comb begin
        asm_d    = asm_q;
        cmd_sh_d = cmd_sh_q;
        hi_sh_d  = hi_sh_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        rdy_d    = rdy_q;

        if (clr_cmd_rdy) begin
            rdy_d = 1'b0;
        end

        if (gap_hit || rx_frm_err) begin
            asm_d = WAIT_CMD;
        end else if (byte_vld) begin
            case (asm_q)
                WAIT_CMD: begin
                    cmd_sh_d = rx_byte;
                    rdy_d    = 1'b0;
                    asm_d    = WAIT_HI;
                end
                WAIT_HI: begin
                    hi_sh_d = rx_byte;
                    asm_d   = WAIT_LO;
                end
                WAIT_LO: begin
                    cmd_d  = cmd_sh_q;
                    data_d = {hi_sh_q, rx_byte};
                    rdy_d  = 1'b1;
                    asm_d  = WAIT_CMD;
                end
                default: asm_d = WAIT_CMD;
            endcase
        end
    end

    // Gap timer counts idle line time inside a frame and saturates at the limit
    always_comb begin
        gap_d = gap_q;
        if (gap_run && (gap_q != GAP_MAX)) begin
            gap_d = gap_q + GW'(1);
        end
        if (byte_vld || (asm_d == WAIT_CMD)) begin
            gap_d = '0;
        end
    end

endmodule

// File: tb/tb_remote_cmd_rx.sv
// tb/tb_remote_cmd_rx.sv - directed self-checking bench for remote_cmd_rx
module tb_remote_cmd_rx;

    localparam int BAUD = 16;
    localparam int GTO  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frm_err;
    logic        gap_err;

    int checks = 0;
    int errors = 0;
    int frm_cnt = 0;
    int gap_cnt = 0;
    int frm_base;
    int gap_base;

    remote_cmd_rx #(
        .BAUD_DIV (BAUD),
        .GAP_TO   (GTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .frm_err     (frm_err),
        .gap_err     (gap_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && frm_err) frm_cnt <= frm_cnt + 1;
        if (!rst && gap_err) gap_cnt <= gap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        cycles(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            cycles(BAUD);
        end
        RX = stop_bit;
        cycles(BAUD);
        RX = 1'b1;
        cycles(4);
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    initial begin
        cycles(3);
        sample;
        check("reset_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("reset_cmd", {24'd0, cmd}, 32'h00);
        check("reset_data", {16'd0, data}, 32'h0000);
        check("reset_frm", {31'd0, frm_err}, 32'd0);
        check("reset_gap", {31'd0, gap_err}, 32'd0);
        @(posedge clk);
        rst = 1'b0;
        cycles(4);

        // Basic frame
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        sample;
        check("f1_rdy_early", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h34, 1'b1);
        sample;
        check("f1_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("f1_cmd", {24'd0, cmd}, 32'h02);
        check("f1_data", {16'd0, data}, 32'h1234);
        check("f1_frm", frm_cnt, 0);
        check("f1_gap", gap_cnt, 0);

        // Consume, then second frame
        @(posedge clk);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        clr_cmd_rdy = 1'b0;
        sample;
        check("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("clr_cmd_hold", {24'd0, cmd}, 32'h02);
        check("clr_data_hold", {16'd0, data}, 32'h1234);
        send_byte(8'h05, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        sample;
        check("f2_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("f2_cmd", {24'd0, cmd}, 32'h05);
        check("f2_data", {16'd0, data}, 32'h01FF);

        // New frame's first byte knocks down an unconsumed cmd_rdy
        send_byte(8'h07, 1'b1);
        sample;
        check("f3_rdy_drop", {31'd0, cmd_rdy}, 32'd0);
        check("f3_cmd_hold", {24'd0, cmd}, 32'h05);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        sample;
        check("f3_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("f3_cmd", {24'd0, cmd}, 32'h07);
        check("f3_data", {16'd0, data}, 32'h0000);

        // Framing error abandons the partial frame
        frm_base = frm_cnt;
        send_byte(8'h03, 1'b1);
        send_byte(8'h55, 1'b0);
        cycles(BAUD);
        sample;
        check("fe_pulses", frm_cnt - frm_base, 1);
        check("fe_cmd_hold", {24'd0, cmd}, 32'h07);
        send_byte(8'h03, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        sample;
        check("fe_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("fe_cmd", {24'd0, cmd}, 32'h03);
        check("fe_data", {16'd0, data}, 32'hABCD);
        check("fe_pulses_end", frm_cnt - frm_base, 1);

        // Inter-byte gap timeout
        gap_base = gap_cnt;
        send_byte(8'h04, 1'b1);
        cycles(150);
        sample;
        check("gap_pulses", gap_cnt - gap_base, 1);
        check("gap_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        sample;
        check("gap_cmd", {24'd0, cmd}, 32'h11);
        check("gap_data", {16'd0, data}, 32'h2233);
        check("gap_rdy_end", {31'd0, cmd_rdy}, 32'd1);
        check("gap_pulses_end", gap_cnt - gap_base, 1);

        // Glitch on RX must not start a byte
        frm_base = frm_cnt;
        @(posedge clk);
        RX = 1'b0;
        cycles(3);
        RX = 1'b1;
        cycles(12 * BAUD);
        sample;
        check("glitch_frm", frm_cnt - frm_base, 0);
        check("glitch_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("glitch_cmd", {24'd0, cmd}, 32'h11);

        // Reset in the middle of the second byte
        send_byte(8'h08, 1'b1);
        RX = 1'b0;
        cycles(BAUD);
        RX = 1'b1;
        cycles(3 * BAUD);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        RX = 1'b1;
        cycles(12 * BAUD);
        sample;
        check("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_cmd", {24'd0, cmd}, 32'h00);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        sample;
        check("post_rst_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("post_rst_cmd", {24'd0, cmd}, 32'h08);
        check("post_rst_data", {16'd0, data}, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
